// File: rtl/iq_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : iq_pkg                                                         |
// | Purpose  : Shared constants and helpers for the issue-queue wakeup/select |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

package iq_pkg;

  localparam int IQ_DEPTH  = 16;
  localparam int PRF_WIDTH = 6;
  localparam int AGE       = 5;
  localparam int IDX_W     = $clog2(IQ_DEPTH);

  // Number of issue/wakeup ports and depth of each wakeup delay line
  localparam int NUM_PORTS = 2;
  localparam int WK_STAGES = 3;

  // Execution latency encodings (0 is treated as single-cycle)
  localparam logic [1:0] LAT_1 = 2'd1;
  localparam logic [1:0] LAT_2 = 2'd2;
  localparam logic [1:0] LAT_3 = 2'd3;

  // Delay-line position (L-1) at which a broadcast with latency 'lat' is booked
  function automatic logic [1:0] lat_slot(input logic [1:0] lat);
    case (lat)
      LAT_2:   lat_slot = 2'd1;
      LAT_3:   lat_slot = 2'd2;
      default: lat_slot = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/age_picker.sv
// ----------------------------------------------------------------------------
// | Module   : age_picker                                                     |
// | Purpose  : Combinational oldest-request selector built as a compare tree; |
// |            equal ages resolve to the lower index                          |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module age_picker #(
  parameter int N     = 16,
  parameter int AGE_W = 5,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]       req,
  input  logic [N*AGE_W-1:0] age,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam int LEVELS = $clog2(N);

  // Level 0 holds the raw requests; each further level halves the survivors.
  // The final compare sits outside the loop because the root age is not needed.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int W = N >> l;
    logic [W-1:0]     v;
    logic [AGE_W-1:0] a [W];
    logic [IDX_W-1:0] x [W];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < W; j++) begin : g_in
        assign v[j] = req[j];
        assign a[j] = age[j*AGE_W +: AGE_W];
        assign x[j] = IDX_W'(j);
      end
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_cmp
        logic w_sel_r;
        // Right child wins only when strictly older, so ties keep the lower index
        assign w_sel_r = g_lvl[l-1].v[2*j+1] &
                         (~g_lvl[l-1].v[2*j] | (g_lvl[l-1].a[2*j+1] < g_lvl[l-1].a[2*j]));
        assign v[j] = g_lvl[l-1].v[2*j] | g_lvl[l-1].v[2*j+1];
        assign a[j] = w_sel_r ? g_lvl[l-1].a[2*j+1] : g_lvl[l-1].a[2*j];
        assign x[j] = w_sel_r ? g_lvl[l-1].x[2*j+1] : g_lvl[l-1].x[2*j];
      end
    end
  end

  logic w_root_sel_r;

  // Root compare between the two surviving halves
  assign w_root_sel_r = g_lvl[LEVELS-1].v[1] &
                        (~g_lvl[LEVELS-1].v[0] | (g_lvl[LEVELS-1].a[1] < g_lvl[LEVELS-1].a[0]));
  assign gnt_valid    = g_lvl[LEVELS-1].v[0] | g_lvl[LEVELS-1].v[1];
  assign gnt_idx      = w_root_sel_r ? g_lvl[LEVELS-1].x[1] : g_lvl[LEVELS-1].x[0];

endmodule

`default_nettype wire

// File: rtl/iq_wakeup_select.sv
// ----------------------------------------------------------------------------
// | Module   : iq_wakeup_select                                               |
// | Purpose  : Dual-port oldest-ready select with registered issue ports and  |
// |            latency-aligned, collision-free wakeup tag broadcast           |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module iq_wakeup_select #(
  parameter int IQ_DEPTH  = iq_pkg::IQ_DEPTH,
  parameter int PRF_WIDTH = iq_pkg::PRF_WIDTH,
  parameter int AGE       = iq_pkg::AGE,
  parameter int IDX_W     = iq_pkg::IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IQ_DEPTH-1:0]           ent_valid,
  input  logic [IQ_DEPTH-1:0]           ent_rdy,
  input  logic [IQ_DEPTH*AGE-1:0]       ent_age,
  input  logic [IQ_DEPTH*PRF_WIDTH-1:0] ent_prd,
  input  logic [IQ_DEPTH-1:0]           ent_prd_v,
  input  logic [IQ_DEPTH*2-1:0]         ent_lat,
  input  logic                          fu_stall,
  input  logic                          flush,
  output logic                          iss0_valid,
  output logic                          iss1_valid,
  output logic [IDX_W-1:0]              iss0_idx,
  output logic [IDX_W-1:0]              iss1_idx,
  output logic [IQ_DEPTH-1:0]           issued_mask,
  output logic                          wk0_valid,
  output logic                          wk1_valid,
  output logic [PRF_WIDTH-1:0]          wk0_tag,
  output logic [PRF_WIDTH-1:0]          wk1_tag
);

  import iq_pkg::*;

  // The reservation register doubles as the valid column of the wakeup delay
  // line: a booked bit is exactly a pending broadcast at that stage.
  logic [WK_STAGES-1:0] r_res     [NUM_PORTS];
  logic [PRF_WIDTH-1:0] r_tag     [NUM_PORTS][WK_STAGES];
  logic                 r_iss_v   [NUM_PORTS];
  logic [IDX_W-1:0]     r_iss_idx [NUM_PORTS];
  logic [IQ_DEPTH-1:0]  r_issued_mask;

  logic [IQ_DEPTH-1:0]  w_cand;
  logic [WK_STAGES-1:0] w_res_sh  [NUM_PORTS];
  logic [IQ_DEPTH-1:0]  w_elig    [NUM_PORTS];
  logic [IQ_DEPTH-1:0]  w_req0;
  logic [IQ_DEPTH-1:0]  w_req1;
  logic [IQ_DEPTH-1:0]  w_win0_oh;
  logic                 w_pick0_v;
  logic                 w_pick1_v;
  logic [IDX_W-1:0]     w_pick0_idx;
  logic [IDX_W-1:0]     w_pick1_idx;
  logic                 w_gnt     [NUM_PORTS];
  logic [IDX_W-1:0]     w_idx     [NUM_PORTS];
  logic [WK_STAGES-1:0] w_load    [NUM_PORTS];
  logic [PRF_WIDTH-1:0] w_tag     [NUM_PORTS];
  logic [IQ_DEPTH-1:0]  w_mask_nxt;

  // Candidates and per-port eligibility against the advanced reservations
  always_comb begin
    w_cand = ent_valid & ent_rdy & ~r_issued_mask;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_res_sh[p] = r_res[p] >> 1;
      w_elig[p]   = '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        w_elig[p][i] = w_cand[i] &
                       (~ent_prd_v[i] | ~w_res_sh[p][lat_slot(ent_lat[2*i +: 2])]);
      end
    end
  end

  // Port 1 competes over its own eligible set minus the port 0 winner
  always_comb begin
    w_win0_oh = '0;
    if (w_pick0_v) begin
      w_win0_oh[w_pick0_idx] = 1'b1;
    end
  end

  assign w_req0 = w_elig[0];
  assign w_req1 = w_elig[1] & ~w_win0_oh;

  age_picker #(
    .N     (IQ_DEPTH),
    .AGE_W (AGE),
    .IDX_W (IDX_W)
  ) u_pick0 (
    .req       (w_req0),
    .age       (ent_age),
    .gnt_valid (w_pick0_v),
    .gnt_idx   (w_pick0_idx)
  );

  age_picker #(
    .N     (IQ_DEPTH),
    .AGE_W (AGE),
    .IDX_W (IDX_W)
  ) u_pick1 (
    .req       (w_req1),
    .age       (ent_age),
    .gnt_valid (w_pick1_v),
    .gnt_idx   (w_pick1_idx)
  );

  // Final grants (stall suppresses them) and the booking each grant makes
  always_comb begin
    w_gnt[0]   = w_pick0_v & ~fu_stall;
    w_gnt[1]   = w_pick1_v & ~fu_stall;
    w_idx[0]   = w_pick0_idx;
    w_idx[1]   = w_pick1_idx;
    w_mask_nxt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_load[p] = '0;
      w_tag[p]  = ent_prd[w_idx[p]*PRF_WIDTH +: PRF_WIDTH];
      if (w_gnt[p]) begin
        w_mask_nxt[w_idx[p]] = 1'b1;
        if (ent_prd_v[w_idx[p]]) begin
          w_load[p] = WK_STAGES'(1) << lat_slot(ent_lat[2*w_idx[p] +: 2]);
        end
      end
    end
  end

  // Issue registers, in-flight mask, reservations and tag delay lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued_mask <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_iss_v[p]   <= 1'b0;
        r_iss_idx[p] <= '0;
        r_res[p]     <= '0;
        for (int k = 0; k < WK_STAGES; k++) begin
          r_tag[p][k] <= '0;
        end
      end
    end else if (flush) begin
      r_issued_mask <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_iss_v[p]   <= 1'b0;
        r_iss_idx[p] <= '0;
        r_res[p]     <= '0;
        for (int k = 0; k < WK_STAGES; k++) begin
          r_tag[p][k] <= '0;
        end
      end
    end else begin
      r_issued_mask <= w_mask_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_iss_v[p]   <= w_gnt[p];
        r_iss_idx[p] <= w_gnt[p] ? w_idx[p] : '0;
        r_res[p]     <= w_res_sh[p] | w_load[p];
        for (int k = 0; k < WK_STAGES - 1; k++) begin
          r_tag[p][k] <= w_load[p][k] ? w_tag[p] : r_tag[p][k+1];
        end
        r_tag[p][WK_STAGES-1] <= w_load[p][WK_STAGES-1] ? w_tag[p] : '0;
      end
    end
  end

  assign iss0_valid  = r_iss_v[0];
  assign iss1_valid  = r_iss_v[1];
  assign iss0_idx    = r_iss_idx[0];
  assign iss1_idx    = r_iss_idx[1];
  assign issued_mask = r_issued_mask;
  assign wk0_valid   = r_res[0][0];
  assign wk1_valid   = r_res[1][0];
  assign wk0_tag     = r_tag[0][0];
  assign wk1_tag     = r_tag[1][0];

endmodule

`default_nettype wire

// File: tb/tb_iq_wakeup_select.sv
// ----------------------------------------------------------------------------
// | Module   : tb_iq_wakeup_select                                            |
// | Purpose  : Self-checking bench with a cycle-indexed booking model         |
// | Revision : 1.0 - initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_iq_wakeup_select;

  localparam int N  = 16;
  localparam int PW = 6;
  localparam int AW = 5;
  localparam int IW = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    ent_valid, ent_rdy, ent_prd_v;
  logic [N*AW-1:0] ent_age;
  logic [N*PW-1:0] ent_prd;
  logic [N*2-1:0]  ent_lat;
  logic            fu_stall, flush;
  logic            iss0_valid, iss1_valid;
  logic [IW-1:0]   iss0_idx, iss1_idx;
  logic [N-1:0]    issued_mask;
  logic            wk0_valid, wk1_valid;
  logic [PW-1:0]   wk0_tag, wk1_tag;

  iq_wakeup_select dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ent_valid   (ent_valid),
    .ent_rdy     (ent_rdy),
    .ent_age     (ent_age),
    .ent_prd     (ent_prd),
    .ent_prd_v   (ent_prd_v),
    .ent_lat     (ent_lat),
    .fu_stall    (fu_stall),
    .flush       (flush),
    .iss0_valid  (iss0_valid),
    .iss1_valid  (iss1_valid),
    .iss0_idx    (iss0_idx),
    .iss1_idx    (iss1_idx),
    .issued_mask (issued_mask),
    .wk0_valid   (wk0_valid),
    .wk1_valid   (wk1_valid),
    .wk0_tag     (wk0_tag),
    .wk1_tag     (wk1_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [39:0] dut_vec;
  assign dut_vec = {iss0_valid, iss0_idx, iss1_valid, iss1_idx, issued_mask,
                    wk0_valid, wk0_tag, wk1_valid, wk1_tag};

  int n_cmp;
  int n_fail;

  // Reference model: broadcasts are booked by absolute cycle number in a ring
  int unsigned ecnt;
  logic        bk_v [2][8];
  logic [PW-1:0] bk_t [2][8];
  logic [N-1:0]  m_prev;
  logic [39:0]   exp_vec;

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 8; s++) begin
        bk_v[p][s] = 1'b0;
        bk_t[p][s] = '0;
      end
    end
    m_prev  = '0;
    exp_vec = '0;
  endtask

  task automatic model_edge();
    int g [2];
    int lat;
    int slot;
    logic [N-1:0] cand;
    logic [N-1:0] m;
    logic [IW-1:0] gi [2];
    logic w_v [2];
    logic [PW-1:0] w_t [2];
    if (!rst_n || flush) begin
      model_clear();
    end else begin
      cand = ent_valid & ent_rdy & ~m_prev;
      g[0] = -1;
      g[1] = -1;
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < N; i++) begin
          if (cand[i] && !(p == 1 && i == g[0])) begin
            lat = int'(ent_lat[i*2 +: 2]);
            if (lat == 0) lat = 1;
            slot = int'((ecnt + lat - 1) % 8);
            if (!ent_prd_v[i] || !bk_v[p][slot]) begin
              if (g[p] < 0 || ent_age[i*AW +: AW] < ent_age[g[p]*AW +: AW]) g[p] = i;
            end
          end
        end
      end
      if (fu_stall) begin
        g[0] = -1;
        g[1] = -1;
      end
      m = '0;
      for (int p = 0; p < 2; p++) begin
        gi[p] = '0;
        if (g[p] >= 0) begin
          m[g[p]] = 1'b1;
          gi[p]   = IW'(g[p]);
          if (ent_prd_v[g[p]]) begin
            lat = int'(ent_lat[g[p]*2 +: 2]);
            if (lat == 0) lat = 1;
            slot = int'((ecnt + lat - 1) % 8);
            bk_v[p][slot] = 1'b1;
            bk_t[p][slot] = ent_prd[g[p]*PW +: PW];
          end
        end
        w_v[p] = bk_v[p][ecnt % 8];
        w_t[p] = bk_t[p][ecnt % 8];
        bk_v[p][ecnt % 8] = 1'b0;
        bk_t[p][ecnt % 8] = '0;
      end
      exp_vec = {g[0] >= 0, gi[0], g[1] >= 0, gi[1], m, w_v[0], w_t[0], w_v[1], w_t[1]};
      m_prev  = m;
    end
    ecnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    ent_valid = '0;
    ent_rdy   = '0;
    ent_prd_v = '0;
    ent_age   = '0;
    ent_prd   = '0;
    ent_lat   = '0;
    fu_stall  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic set_ent(input int i, input int age, input int tag, input bit pv, input int lat);
    ent_valid[i]          = 1'b1;
    ent_rdy[i]            = 1'b1;
    ent_prd_v[i]          = pv;
    ent_age[i*AW +: AW]   = AW'(age);
    ent_prd[i*PW +: PW]   = PW'(tag);
    ent_lat[i*2 +: 2]     = 2'(lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    step();
    step();
    n_cmp++;
    if (dut_vec !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec, 40'd0);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_idle_model: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_age_order();
    drain();
    set_ent(3, 7, 'h03, 1'b0, 1);
    set_ent(9, 2, 'h09, 1'b0, 1);
    set_ent(12, 5, 'h0c, 1'b0, 1);
    step();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid, iss1_idx, issued_mask} !== {1'b1, 4'd9, 1'b1, 4'd12, 16'h1200}) begin
      n_fail++;
      $display("FAIL age_order_first: got v%b i%0d v%b i%0d m%h want v1 i9 v1 i12 m1200",
               iss0_valid, iss0_idx, iss1_valid, iss1_idx, issued_mask);
    end
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL age_order_model1: got %h want %h", dut_vec, exp_vec);
    end
    step();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid} !== {1'b1, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL age_order_masked: got v%b i%0d v1=%b want v1 i3 v1=0", iss0_valid, iss0_idx, iss1_valid);
    end
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL age_order_model2: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_wakeup_latency();
    drain();
    set_ent(0, 3, 'h15, 1'b1, 3);
    step();
    idle_inputs();
    n_cmp++;
    if ({iss0_valid, iss0_idx, wk0_valid} !== {1'b1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL wk_lat_issue: got v%b i%0d wk%b want v1 i0 wk0", iss0_valid, iss0_idx, wk0_valid);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if ({wk0_valid, wk0_tag} !== ((k == 2) ? {1'b1, 6'h15} : {1'b0, 6'h00})) begin
        n_fail++;
        $display("FAIL wk_lat_cycle%0d: got v%b t%h want v%b", k, wk0_valid, wk0_tag, k == 2);
      end
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL wk_lat_model%0d: got %h want %h", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reservation();
    drain();
    set_ent(0, 3, 'h21, 1'b1, 3);
    step();
    idle_inputs();
    step();
    set_ent(4, 1, 'h04, 1'b1, 1);
    set_ent(5, 2, 'h05, 1'b1, 1);
    step();
    n_cmp++;
    if ({iss0_valid, iss1_valid, iss1_idx, wk0_valid, wk0_tag, wk1_valid, wk1_tag} !==
        {1'b0, 1'b1, 4'd4, 1'b1, 6'h21, 1'b1, 6'h04}) begin
      n_fail++;
      $display("FAIL resv_conflict: got %h want iss0 idle, iss1=4, wk0=21, wk1=04", dut_vec);
    end
    step();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid, wk0_valid, wk0_tag} !== {1'b1, 4'd5, 1'b0, 1'b1, 6'h05}) begin
      n_fail++;
      $display("FAIL resv_followup: got %h want iss0=5 only, wk0=05", dut_vec);
    end
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL resv_model: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_stall();
    drain();
    set_ent(1, 0, 'h2a, 1'b1, 3);
    step();
    idle_inputs();
    for (int i = 2; i < 6; i++) set_ent(i, i + 2, i, 1'b0, 1);
    fu_stall = 1'b1;
    step();
    n_cmp++;
    if ({iss0_valid, iss1_valid, issued_mask, wk0_valid} !== {1'b0, 1'b0, 16'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_c1: got %h want no issue, no wakeup", dut_vec);
    end
    step();
    n_cmp++;
    if ({iss0_valid, iss1_valid, issued_mask, wk0_valid, wk0_tag} !== {1'b0, 1'b0, 16'h0, 1'b1, 6'h2a}) begin
      n_fail++;
      $display("FAIL stall_c2: got %h want no issue, wk0=2a", dut_vec);
    end
    fu_stall = 1'b0;
    step();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid, iss1_idx} !== {1'b1, 4'd2, 1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL stall_release: got %h want iss0=2 iss1=3", dut_vec);
    end
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL stall_model: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_flush();
    drain();
    set_ent(6, 1, 'h36, 1'b1, 3);
    set_ent(7, 2, 'h37, 1'b1, 3);
    step();
    idle_inputs();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid, iss1_idx} !== {1'b1, 4'd6, 1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL flush_setup: got %h want iss0=6 iss1=7", dut_vec);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (dut_vec !== 40'd0) begin
      n_fail++;
      $display("FAIL flush_clear: got %h want 0", dut_vec);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({wk0_valid, wk1_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL flush_no_wake%0d: got wk0=%b wk1=%b want 0 0", k, wk0_valid, wk1_valid);
      end
    end
  endtask

  task automatic test_no_dest();
    drain();
    set_ent(0, 1, 'h10, 1'b1, 3);
    set_ent(1, 2, 'h11, 1'b1, 3);
    step();
    idle_inputs();
    step();
    set_ent(9, 0, 'h19, 1'b1, 1);
    set_ent(8, 3, 'h18, 1'b0, 1);
    set_ent(10, 4, 'h1a, 1'b0, 2);
    step();
    idle_inputs();
    n_cmp++;
    if ({iss0_valid, iss0_idx, iss1_valid, iss1_idx, wk0_valid, wk0_tag, wk1_valid, wk1_tag} !==
        {1'b1, 4'd8, 1'b1, 4'd10, 1'b1, 6'h10, 1'b1, 6'h11}) begin
      n_fail++;
      $display("FAIL nodest_issue: got %h want iss0=8 iss1=10 wk0=10 wk1=11", dut_vec);
    end
    step();
    n_cmp++;
    if ({wk0_valid, wk1_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL nodest_no_wake: got wk0=%b wk1=%b want 0 0", wk0_valid, wk1_valid);
    end
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL nodest_model: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_async_reset();
    drain();
    set_ent(2, 0, 'h2b, 1'b1, 1);
    step();
    idle_inputs();
    n_cmp++;
    if ({wk0_valid, wk0_tag} !== {1'b1, 6'h2b}) begin
      n_fail++;
      $display("FAIL areset_pre: got wk0=%b t%h want 1 2b", wk0_valid, wk0_tag);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 40'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h want 0", dut_vec);
    end
    model_clear();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL areset_after: got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    int perm [32];
    int j;
    int t;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 32; i++) perm[i] = i;
      for (int i = 31; i > 0; i--) begin
        j       = int'($urandom_range(0, i));
        t       = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      ent_valid = N'($urandom);
      ent_rdy   = N'($urandom | $urandom);
      ent_prd_v = N'($urandom);
      ent_lat   = $urandom;
      for (int i = 0; i < N; i++) begin
        ent_age[i*AW +: AW] = AW'(perm[i]);
        ent_prd[i*PW +: PW] = PW'($urandom);
      end
      fu_stall = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      step();
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_c%0d: got %h want %h", c, dut_vec, exp_vec);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    ecnt   = 0;
    test_reset();
    test_age_order();
    test_wakeup_latency();
    test_reservation();
    test_stall();
    test_flush();
    test_no_dest();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
